// File: rtl/fibo_pkg.sv
// Shared types and default sizes for the Fibonacci/Lucas sequence engine.
package fibo_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_IDX_W  = 6;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } fibo_state_t;

endpackage

// File: rtl/fibo_add_step.sv
// One recurrence step of the sequence engine: shifts the term window and
// forms the next term together with its carry-out. Purely combinational.
module fibo_add_step
  import fibo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [IDX_W-1:0]  cnt,
  output logic [DATA_W-1:0] next_a,
  output logic [DATA_W-1:0] next_b,
  output logic              carry,
  output logic              last
);

  // Unsigned add with one extra bit to expose the carry lost on truncation.
  always_comb begin
    next_a          = b;
    {carry, next_b} = {1'b0, a} + {1'b0, b};
    last            = (cnt == '0);
  end

endmodule

// File: rtl/fibo_seq_engine.sv
// Multi-cycle sequence engine: computes X(n) of X(k)=X(k-1)+X(k-2) from
// caller-supplied seeds, with start/busy/done handshake, abort and sticky
// overflow detection.
// Optional build macro: FIBO_SATURATE_EN -- when defined, a result whose
// computation overflowed is replaced by the all-ones value.
module fibo_seq_engine
  import fibo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W-1:0]  n_in,
  input  logic [DATA_W-1:0] seed0,
  input  logic [DATA_W-1:0] seed1,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);

  fibo_state_t       state;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [IDX_W-1:0]  cnt;
  logic              ovf;

  logic [DATA_W-1:0] next_a;
  logic [DATA_W-1:0] next_b;
  logic              carry;
  logic              last;

`ifdef FIBO_SATURATE_EN
  function automatic logic [DATA_W-1:0] sat_result(input logic [DATA_W-1:0] val,
                                                    input logic              ovf_flag);
    return ovf_flag ? {DATA_W{1'b1}} : val;
  endfunction
`endif

  fibo_add_step #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_step (
    .a      (a),
    .b      (b),
    .cnt    (cnt),
    .next_a (next_a),
    .next_b (next_b),
    .carry  (carry),
    .last   (last)
  );

  // Control FSM, term window and registered outputs. The cnt==1 step only
  // produces X(n+1), so its carry must not mark the result as overflowed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      a        <= '0;
      b        <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            a     <= seed0;
            b     <= seed1;
            cnt   <= n_in;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (last) begin
`ifdef FIBO_SATURATE_EN
            result <= sat_result(a, ovf);
`else
            result <= a;
`endif
            overflow <= ovf;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            a   <= next_a;
            b   <= next_b;
            cnt <= cnt - 1'b1;
            if (carry && (cnt > IDX_W'(1))) begin
              ovf <= 1'b1;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fibo_seq_engine.sv
// Self-checking bench for fibo_seq_engine (16-bit build) against a
// full-precision arithmetic reference of the recurrence.
module tb_fibo_seq_engine;

  localparam int DW = 16;
  localparam int IW = 6;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [IW-1:0] n_in;
  logic [DW-1:0] seed0;
  logic [DW-1:0] seed1;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic          overflow;

  int n_checks;
  int n_fail;

  fibo_seq_engine #(
    .DATA_W (DW),
    .IDX_W  (IW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .n_in     (n_in),
    .seed0    (seed0),
    .seed1    (seed1),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint unsigned got,
                           input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Exact X(n) with no truncation; 16-bit seeds and n<=63 fit in 64 bits.
  function automatic longint unsigned fib_true(input int n, input longint unsigned s0,
                                               input longint unsigned s1);
    longint unsigned x0, x1, t;
    x0 = s0;
    x1 = s1;
    if (n == 0) return x0;
    for (int k = 2; k <= n; k++) begin
      t  = x0 + x1;
      x0 = x1;
      x1 = t;
    end
    return x1;
  endfunction

  // Terms from X(2) on never decrease, so overflow means the exact X(n)
  // does not fit in DW bits (seeds themselves always fit).
  function automatic bit exp_ovf(input int n, input longint unsigned s0,
                                 input longint unsigned s1);
    return (n >= 2) && ((fib_true(n, s0, s1) >> DW) != 0);
  endfunction

  function automatic longint unsigned exp_res(input int n, input longint unsigned s0,
                                              input longint unsigned s1);
    longint unsigned v;
    v = fib_true(n, s0, s1) & ((64'd1 << DW) - 1);
`ifdef FIBO_SATURATE_EN
    if (exp_ovf(n, s0, s1)) v = (64'd1 << DW) - 1;
`endif
    return v;
  endfunction

  // Drive a request for one edge; returns #1 after the accepting edge.
  task automatic start_req(input int n, input longint unsigned s0, input longint unsigned s1);
    n_in  = IW'(n);
    seed0 = DW'(s0);
    seed1 = DW'(s1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait for done after an accept; pre = edges already elapsed since accept.
  task automatic wait_done(input string tag, input int pre, input int n,
                           input longint unsigned s0, input longint unsigned s1);
    int lat;
    int busy_cnt;
    bit got;
    lat      = pre;
    busy_cnt = pre + (busy ? 1 : 0);
    got      = 1'b0;
    while (!got && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) got = 1'b1;
      else if (busy) busy_cnt++;
    end
    check_val({tag, "_latency"}, lat, n + 1);
    check_val({tag, "_result"}, result, exp_res(n, s0, s1));
    check_val({tag, "_overflow"}, overflow, exp_ovf(n, s0, s1));
    check_val({tag, "_busy_at_done"}, busy, 0);
    check_val({tag, "_busy_cycles"}, busy_cnt, n + 1);
  endtask

  initial begin
    int dcount;
    int rn;
    longint unsigned rs0, rs1;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    n_in     = '0;
    seed0    = '0;
    seed1    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_result", result, 0);
    check_val("rst_overflow", overflow, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    start_req(0, 0, 1);
    wait_done("fib_n0", 0, 0, 0, 1);
    start_req(10, 0, 1);
    wait_done("fib_n10", 0, 10, 0, 1);
    check_val("fib_n10_abs", result, 55);

    // Back-to-back request issued in the done cycle
    start_req(5, 2, 1);
    wait_done("lucas_n5", 0, 5, 2, 1);
    start_req(1, 2, 1);
    wait_done("lucas_b2b_n1", 0, 1, 2, 1);
    check_val("lucas_b2b_abs", result, 1);

    start_req(24, 0, 1);
    wait_done("fib_n24", 0, 24, 0, 1);
    check_val("fib_n24_abs", result, 46368);
    start_req(25, 0, 1);
    wait_done("fib_n25", 0, 25, 0, 1);
`ifdef FIBO_SATURATE_EN
    check_val("fib_n25_abs", result, 65535);
`else
    check_val("fib_n25_abs", result, 9489);
`endif

    // Start pulse while busy must be ignored
    start_req(20, 0, 1);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    n_in  = 6'd3;
    seed0 = 16'd7;
    seed1 = 16'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignored_start", 7, 20, 0, 1);
    check_val("ignored_start_abs", result, 6765);

    // Abort when cnt has reached 7
    start_req(20, 0, 1);
    repeat (13) begin
      @(posedge clk);
      #1;
    end
    check_val("abort_busy_before", busy, 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check_val("abort_busy_after", busy, 0);
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) dcount++;
      @(posedge clk);
      #1;
    end
    check_val("abort_no_done", dcount, 0);
    check_val("abort_result_kept", result, 6765);
    check_val("abort_ovf_kept", overflow, 0);

    // Abort in IDLE blocks a simultaneous start
    n_in  = 6'd2;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check_val("idle_abort_busy", busy, 0);
    dcount = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check_val("idle_abort_no_done", dcount, 0);

    // Randomized requests
    for (int t = 0; t < 24; t++) begin
      rn  = int'($urandom_range(0, 63));
      rs0 = longint'($urandom_range(0, 65535));
      rs1 = longint'($urandom_range(0, 65535));
      if (t % 3 == 0) begin
        rs0 = longint'($urandom_range(0, 20));
        rs1 = longint'($urandom_range(0, 20));
      end
      start_req(rn, rs0, rs1);
      wait_done($sformatf("rand%0d_n%0d", t, rn), 0, rn, rs0, rs1);
    end

    // Asynchronous reset in the middle of a calculation
    start_req(25, 0, 1);
    wait_done("pre_reset_n25", 0, 25, 0, 1);
    start_req(30, 3, 4);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_val("midrst_busy", busy, 0);
    check_val("midrst_done", done, 0);
    check_val("midrst_result", result, 0);
    check_val("midrst_overflow", overflow, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    start_req(12, 0, 1);
    wait_done("post_reset_n12", 0, 12, 0, 1);
    check_val("post_reset_abs", result, 144);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
